// File: rtl/regfile_sched_pkg.sv
// Shared CPU types and scheduler defaults.
package regfile_sched_pkg;

    typedef logic [31:0] rv32i_word;
    typedef logic [4:0]  rv32i_reg;

    localparam int unsigned STARVE_MAX_DEFAULT = 3;
    localparam rv32i_reg    LAST_REG           = 5'd31;

    typedef enum logic {
        NORMAL = 1'b0,
        WALK   = 1'b1
    } sched_state_e;

endpackage

// File: rtl/regfile_sched.sv
// Arbitrates decoder tag writes and ROB commits onto the regfile ports,
// and walks x1..x31 clearing rename tags on a flush.
module regfile_sched
    import regfile_sched_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      dec_valid,
    output logic      dec_ready,
    input  rv32i_reg  dec_rd,
    input  rv32i_reg  dec_tag,
    input  logic      rob_valid,
    output logic      rob_ready,
    input  rv32i_reg  rob_rd,
    input  rv32i_reg  rob_tag,
    input  rv32i_word rob_val,
    input  logic      flush_req,
    output logic      load_reg,
    output rv32i_reg  reg_id_rob,
    output rv32i_word reg_val,
    output rv32i_reg  tag_rob,
    output logic      load_tag,
    output rv32i_reg  reg_id_decoder,
    output rv32i_reg  tag_decoder,
    output logic      busy
);

    localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

    sched_state_e state, next_state;
    rv32i_reg     idx, idx_next;
    logic [1:0]   stall_cnt;
    logic         starved;
    logic         dec_wr, rob_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= NORMAL;
            idx   <= '0;
        end else begin
            state <= next_state;
            idx   <= idx_next;
        end
    end

    // idx wraps 31 -> 0 on the final walk step, which leaves it cleared for the next flush
    always_comb begin
        next_state = state;
        idx_next   = idx;
        dec_ready  = 1'b0;
        rob_ready  = 1'b0;
        starved    = (stall_cnt == STARVE_LIM);
        case (state)
            NORMAL: begin
                if (flush_req) begin
                    next_state = WALK;
                    idx_next   = 5'd1;
                end else if (!rst) begin
                    rob_ready = rob_valid && !(dec_valid && starved);
                    dec_ready = dec_valid && !rob_ready;
                end
            end
            WALK: begin
                idx_next = idx + 5'd1;
                if (idx == LAST_REG) next_state = NORMAL;
            end
            default: next_state = NORMAL;
        endcase
    end

    assign dec_wr = dec_ready && (dec_rd != '0);
    assign rob_wr = rob_ready && (rob_rd != '0);
    assign busy   = (state == WALK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == NORMAL) begin
            if (dec_ready) begin
                stall_cnt <= '0;
            end else if (dec_valid && stall_cnt != STARVE_LIM) begin
                stall_cnt <= stall_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_reg       <= 1'b0;
            reg_id_rob     <= '0;
            reg_val        <= '0;
            tag_rob        <= '0;
            load_tag       <= 1'b0;
            reg_id_decoder <= '0;
            tag_decoder    <= '0;
        end else begin
            load_reg   <= rob_wr;
            reg_id_rob <= rob_wr ? rob_rd  : '0;
            reg_val    <= rob_wr ? rob_val : '0;
            tag_rob    <= rob_wr ? rob_tag : '0;
            if (next_state == WALK) begin
                load_tag       <= 1'b1;
                reg_id_decoder <= idx_next;
                tag_decoder    <= '0;
            end else begin
                load_tag       <= dec_wr;
                reg_id_decoder <= dec_wr ? dec_rd  : '0;
                tag_decoder    <= dec_wr ? dec_tag : '0;
            end
        end
    end

endmodule
